mod_unit_32bit: RTL and testbench
=================================

MOD_UNIT_32BIT -- requirements
Module: mod_unit_32bit

Interface
REQ-001 The block SHALL have one clock and a reset that is asynchronous and active-high.
REQ-002 The block SHALL have no parameters; the data width is fixed at 32 bits.
REQ-003 Port clk: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 Port reset: input, 1 bit, asynchronous active-high reset.
REQ-005 Port start: input, 1 bit, request to begin an operation; sampled only in IDLE.
REQ-006 Port a: input, 32 bits, unsigned dividend.
REQ-007 Port b: input, 32 bits, unsigned divisor.
REQ-008 Port remainder: output, 32 bits, registered a mod b; drives the ALU result mux input for the MOD opcode.
REQ-009 Port quotient: output, 32 bits, registered a / b.
REQ-010 Port done: output, 1 bit, one-cycle pulse marking that the result is valid.
REQ-011 Port busy: output, 1 bit, high while state is RUN.
REQ-012 Port dz: output, 1 bit, registered divide-by-zero flag for the last operation.

Function
REQ-013 The block SHALL use three FSM states, IDLE, RUN and DONE, with a 5-bit iteration counter cnt.
- IDLE: waits for start.
- RUN: performs 32 restoring iterations.
- DONE: drives done; always returns to IDLE on the next edge.
REQ-014 In IDLE with start=1 and b!=0, on the edge (edge 0) the block SHALL latch a into shift register D and b into Bq, clear the 33-bit partial remainder R and cnt, and go to RUN.
REQ-015 In IDLE with start=1 and b==0, on edge 0 the block SHALL load remainder<=a, quotient<=32'hFFFFFFFF and dz<=1, then go to DONE.
REQ-016 Each RUN cycle SHALL compute T={R[31:0],D[31]}.
- If T>={1'b0,Bq}: R<=T-Bq and D<={D[30:0],1'b1}.
- Otherwise: R<=T and D<={D[30:0],1'b0}.
- In both cases cnt<=cnt+1.
REQ-017 The comparison and subtraction SHALL be 33-bit unsigned, with no truncation before the compare.
REQ-018 On the RUN edge where cnt==31 (edge 32), the block SHALL load remainder and quotient from the post-iteration R[31:0] and D, set dz<=0, and go to DONE.
REQ-019 done SHALL equal (state==DONE).
- Normal operation: high exactly between edge 32 and edge 33.
- Divide by zero: high between edge 0 and edge 1.
REQ-020 remainder, quotient and dz SHALL hold their values until the next operation completes; they SHALL NOT change in IDLE or RUN.
REQ-021 start asserted in RUN or DONE SHALL be ignored, with no effect on latched operands or outputs.
REQ-022 Changes on a or b after edge 0 SHALL NOT affect the operation in progress.
REQ-023 Back-to-back use SHALL be allowed: start held high in IDLE directly after DONE begins a new operation on that edge.

Reset
REQ-024 While reset=1, asynchronously and regardless of clk, the block SHALL set:
- state=IDLE;
- cnt, D, Bq and R to 0;
- remainder=0, quotient=0;
- done=0, busy=0, dz=0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after reset deasserts SHALL operate normally.

Verification
REQ-026 a=7, b=3, start pulse -> busy for 32 cycles; done pulses once at edge 32; remainder=1, quotient=2, dz=0.
REQ-027 a=32'hFFFFFFFF, b=1 -> at edge 32: remainder=0, quotient=32'hFFFFFFFF.
REQ-028 a=32'h80000000, b=32'hFFFFFFFF -> remainder=32'h80000000, quotient=0 (exercises the 33-bit compare); then a=3, b=10 -> remainder=3, quotient=0.
REQ-029 a=5, b=0 -> done high in the cycle after edge 0, busy never high; remainder=5, quotient=32'hFFFFFFFF, dz=1.
REQ-030 a=100, b=7; at iteration 10 toggle start and change a to 9 -> ignored, result remainder=2, quotient=14. Repeat, and assert reset at iteration 10 -> all outputs 0 immediately, no done pulse; a subsequent a=100, b=7 run still gives remainder=2.
REQ-031 Randomised check of 1000 operand pairs against a reference model: remainder==a%b and quotient==a/b for b!=0; done asserted exactly once per accepted start.

Source files
------------

// File: rtl/mod_unit_32bit.sv
// 32-bit unsigned divider/modulo unit: restoring division, one quotient bit per cycle.
// Divide-by-zero short-circuits to remainder=a, quotient=all ones, dz=1.
module mod_unit_32bit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] remainder,
    output logic [31:0] quotient,
    output logic        done,
    output logic        busy,
    output logic        dz
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic [31:0] d, bq;
    logic [32:0] r;
    logic [32:0] t, diff, r_nx;
    logic [31:0] d_nx;
    logic        ge;

    // A set bit shifted out of R means T already exceeds any 32-bit divisor.
    assign t    = {r[31:0], d[31]};
    assign diff = t - {1'b0, bq};
    assign ge   = r[32] | (t >= {1'b0, bq});
    assign r_nx = ge ? diff : t;
    assign d_nx = {d[30:0], ge};

    assign done = (state == DONE);
    assign busy = (state == RUN);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (b == 32'd0) ? DONE : RUN;
            RUN:     if (cnt == 5'd31) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 5'd0;
            d         <= 32'd0;
            bq        <= 32'd0;
            r         <= 33'd0;
            remainder <= 32'd0;
            quotient  <= 32'd0;
            dz        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b == 32'd0) begin
                            remainder <= a;
                            quotient  <= 32'hFFFF_FFFF;
                            dz        <= 1'b1;
                        end else begin
                            d   <= a;
                            bq  <= b;
                            r   <= 33'd0;
                            cnt <= 5'd0;
                        end
                    end
                end
                RUN: begin
                    r   <= r_nx;
                    d   <= d_nx;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        remainder <= r_nx[31:0];
                        quotient  <= d_nx;
                        dz        <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_unit_32bit.sv
// Self-checking bench for mod_unit_32bit: directed literal cases plus randomized
// traffic compared every cycle against a timeline model built on a%b and a/b.
module tb_mod_unit_32bit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [31:0] remainder, quotient;
    logic        done, busy, dz;

    mod_unit_32bit dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .remainder(remainder), .quotient(quotient),
        .done(done), .busy(busy), .dz(dz)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: a result is due 32 edges after an accepted start (b!=0),
    // or on the accept edge itself for b==0; done lasts one cycle, then idle.
    logic [31:0] m_rem = '0, m_quo = '0, p_rem = '0, p_quo = '0;
    logic        m_dz = 1'b0, m_done = 1'b0;
    int          m_left = 0, m_acc = 0, m_cmpl = 0, n_done_seen = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem <= '0; m_quo <= '0; m_dz <= 1'b0; m_done <= 1'b0; m_left <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_rem <= p_rem; m_quo <= p_quo; m_dz <= 1'b0;
                m_done <= 1'b1; m_cmpl <= m_cmpl + 1;
            end
        end else if (start) begin
            m_acc <= m_acc + 1;
            if (b == 32'd0) begin
                m_rem <= a; m_quo <= 32'hFFFF_FFFF; m_dz <= 1'b1;
                m_done <= 1'b1; m_cmpl <= m_cmpl + 1;
            end else begin
                p_rem <= a % b; p_quo <= a / b; m_left <= 32;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_remainder", remainder, m_rem);
        chk("cyc_quotient", quotient, m_quo);
        chk("cyc_dz", {31'd0, dz}, {31'd0, m_dz});
        chk("cyc_done", {31'd0, done}, {31'd0, m_done});
        chk("cyc_busy", {31'd0, busy}, {31'd0, m_left != 0});
        if (done === 1'b1) n_done_seen++;
    end

    // Pulse start for one operation, wait (bounded) for done, check literals.
    task automatic run_lit(input logic [31:0] ta, input logic [31:0] tb_v,
                           input logic [31:0] er, input logic [31:0] eq,
                           input logic edz, input int ebusy, input string nm);
        int   bc;
        logic got;
        @(negedge clk); a = ta; b = tb_v; start = 1'b1;
        @(negedge clk); start = 1'b0;
        bc  = busy ? 1 : 0;
        got = done;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) got = 1'b1;
        end
        chk({nm, "_done"}, {31'd0, got}, 32'd1);
        chk({nm, "_rem"}, remainder, er);
        chk({nm, "_quo"}, quotient, eq);
        chk({nm, "_dz"}, {31'd0, dz}, {31'd0, edz});
        chk({nm, "_busycyc"}, bc, ebusy);
    endtask

    initial begin
        int cyc;
        #1;
        chk("rst_rem", remainder, 32'd0);
        chk("rst_quo", quotient, 32'd0);
        chk("rst_flags", {29'd0, done, busy, dz}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_lit(32'd7, 32'd3, 32'd1, 32'd2, 1'b0, 32, "d7_3");
        run_lit(32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 32, "dmax_1");
        run_lit(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 32, "d33bit");
        run_lit(32'd3, 32'd10, 32'd3, 32'd0, 1'b0, 32, "d3_10");
        run_lit(32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 0, "divzero");

        // Start toggled and a changed mid-run must be ignored.
        @(negedge clk); a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; a = 32'd9;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin @(negedge clk); cyc++; end
        chk("midstart_done", {31'd0, done}, 32'd1);
        chk("midstart_rem", remainder, 32'd2);
        chk("midstart_quo", quotient, 32'd14);

        // Reset mid-run aborts and clears outputs asynchronously.
        @(negedge clk); a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_rem", remainder, 32'd0);
        chk("abort_quo", quotient, 32'd0);
        chk("abort_flags", {29'd0, done, busy, dz}, 32'd0);
        @(negedge clk); reset = 1'b0;
        run_lit(32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32, "after_rst");

        // Randomized traffic: start often held high (back-to-back), operands
        // churn every cycle, occasional zero or small divisors.
        cyc = 0;
        while (m_acc < 1000 + 8 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            start = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = $urandom_range(1, 15);
                3:       b = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: b = $urandom;
            endcase
            a = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 7) : $urandom;
        end
        chk("rand_budget", {31'd0, cyc < 60000}, 32'd1);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("done_count", n_done_seen, m_cmpl);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
